// File: rtl/turn_pkg.sv
// Shared state encoding, direction constants and configuration helpers
// for the turn scheduler.
package turn_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // A game always needs at least two seats and never more than the board has.
    function automatic int unsigned clamp_players(input int unsigned n, input int unsigned max_p);
        if (n < 2) begin
            return 2;
        end
        if (n > max_p) begin
            return max_p;
        end
        return n;
    endfunction

endpackage

// File: rtl/ring_next_finder.sv
// Combinational ring search: nearest active seat after i_cur in the given
// direction among seats below i_n, plus a wrap flag and the active popcount.
module ring_next_finder
    import turn_pkg::*;
#(
    parameter int unsigned MAX_PLAYERS = 4,
    localparam int unsigned PW = $clog2(MAX_PLAYERS)
) (
    input  logic [PW-1:0]          i_cur,
    input  logic                   i_dir,
    input  logic [PW:0]            i_n,
    input  logic [MAX_PLAYERS-1:0] i_mask,
    output logic [PW-1:0]          o_next,
    output logic                   o_found,
    output logic                   o_wrap,
    output logic [PW:0]            o_count
);

    always_comb begin
        int unsigned idx;
        logic [PW-1:0] w_idx;
        idx     = 0;
        w_idx   = '0;
        o_next  = i_cur;
        o_found = 1'b0;
        o_count = '0;
        for (int i = 0; i < int'(MAX_PLAYERS); i++) begin
            o_count = o_count + {{PW{1'b0}}, i_mask[i]};
        end
        // Walk farthest-to-nearest so the nearest active seat is the last write.
        for (int k = int'(MAX_PLAYERS) - 1; k >= 1; k--) begin
            if (k < int'(i_n)) begin
                if (i_dir == DIR_UP) begin
                    idx = 32'(i_cur) + 32'(k);
                end else begin
                    idx = 32'(i_cur) + 32'(i_n) - 32'(k);
                end
                if (idx >= 32'(i_n)) begin
                    idx = idx - 32'(i_n);
                end
                w_idx = PW'(idx);
                if (i_mask[w_idx]) begin
                    o_next  = w_idx;
                    o_found = 1'b1;
                end
            end
        end
        o_wrap = o_found && ((i_dir == DIR_UP) ? (o_next < i_cur) : (o_next > i_cur));
    end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: steps through active seats on each rising edge of i_advance,
// counts rounds, honours direction reversal and halts when one seat is left.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int unsigned MAX_PLAYERS = 4,
    parameter int unsigned ROUND_W = 8,
    localparam int unsigned PW = $clog2(MAX_PLAYERS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [PW:0]            i_num_players,
    input  logic [MAX_PLAYERS-1:0] i_active_mask,
    input  logic                   i_advance,
    input  logic                   i_reverse,
    output logic [PW-1:0]          o_turn,
    output logic [MAX_PLAYERS-1:0] o_turn_onehot,
    output logic                   o_direction,
    output logic [ROUND_W-1:0]     o_round_count,
    output logic                   o_new_round,
    output logic                   o_game_active,
    output logic                   o_winner_valid,
    output logic [PW-1:0]          o_winner
);

    localparam int unsigned NW = PW + 1;

    state_t                   r_state;
    logic [NW-1:0]            r_n;
    logic [PW-1:0]            r_turn;
    logic [MAX_PLAYERS-1:0]   r_onehot;
    logic                     r_dir;
    logic [ROUND_W-1:0]       r_round;
    logic                     r_new_round;
    logic                     r_game_active;
    logic                     r_winner_valid;
    logic [PW-1:0]            r_winner;
    logic                     r_adv_q;

    logic                     w_edge;
    logic                     w_dir_eff;
    logic [MAX_PLAYERS-1:0]   w_live;
    logic [PW-1:0]            w_lone;
    logic [PW-1:0]            w_next;
    logic                     w_found;
    logic                     w_wrap;
    logic [NW-1:0]            w_count;

    assign w_edge    = i_advance & ~r_adv_q;
    assign w_dir_eff = r_dir ^ i_reverse;

    // Seats at or beyond the configured count never take part.
    always_comb begin
        w_live = '0;
        w_lone = '0;
        for (int i = 0; i < int'(MAX_PLAYERS); i++) begin
            w_live[i] = i_active_mask[i] && (i < int'(r_n));
            if (w_live[i]) begin
                w_lone = PW'(i);
            end
        end
    end

    ring_next_finder #(
        .MAX_PLAYERS (MAX_PLAYERS)
    ) u_finder (
        .i_cur   (r_turn),
        .i_dir   (w_dir_eff),
        .i_n     (r_n),
        .i_mask  (w_live),
        .o_next  (w_next),
        .o_found (w_found),
        .o_wrap  (w_wrap),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_n            <= NW'(2);
            r_turn         <= '0;
            r_onehot       <= '0;
            r_dir          <= DIR_UP;
            r_round        <= '0;
            r_new_round    <= 1'b0;
            r_game_active  <= 1'b0;
            r_winner_valid <= 1'b0;
            r_winner       <= '0;
            r_adv_q        <= 1'b0;
        end else begin
            r_adv_q     <= i_advance;
            r_new_round <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state       <= ST_RUN;
                        r_n           <= NW'(clamp_players(32'(i_num_players), MAX_PLAYERS));
                        r_turn        <= '0;
                        r_onehot      <= {{(MAX_PLAYERS-1){1'b0}}, 1'b1};
                        r_dir         <= DIR_UP;
                        r_round       <= '0;
                        r_game_active <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Halting takes priority over any step or reversal this cycle.
                    if (w_count <= NW'(1)) begin
                        r_state        <= ST_HALT;
                        r_onehot       <= '0;
                        r_game_active  <= 1'b0;
                        r_winner_valid <= (w_count == NW'(1));
                        r_winner       <= w_lone;
                    end else begin
                        r_dir <= w_dir_eff;
                        if (w_edge && w_found) begin
                            r_turn   <= w_next;
                            r_onehot <= {{(MAX_PLAYERS-1){1'b0}}, 1'b1} << w_next;
                            if (w_wrap && (r_round != {ROUND_W{1'b1}})) begin
                                r_round     <= r_round + 1'b1;
                                r_new_round <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_turn         = r_turn;
    assign o_turn_onehot  = r_onehot;
    assign o_direction    = r_dir;
    assign o_round_count  = r_round;
    assign o_new_round    = r_new_round;
    assign o_game_active  = r_game_active;
    assign o_winner_valid = r_winner_valid;
    assign o_winner       = r_winner;

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Parametrised turn sequencer for the Chicken Cha-Cha-Cha board controller. It supports any player count up to `MAX_PLAYERS`, eliminated-player skipping, reversible play direction, round counting and winner detection. It sits between the game-state decoder, which raises `advance` when a move completes, and the display/score logic, which consumes `turn`, `round_count` and the winner flags.

## Interface
- `MAX_PLAYERS`, default 4: maximum seat count; must be ≥2.
- `ROUND_W`, default 8: width of the round counter.
- `PW` (localparam): `$clog2(MAX_PLAYERS)`, the player-index width.
- `clk`  in  1  system clock; every register is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that latches the configuration and begins a game.
- `num_players`  in  PW+1  seats in use, sampled only on an accepted `start`.
- `active_mask`  in  MAX_PLAYERS  bit i=1 means player i is still in the game; live input.
- `advance`  in  1  level from the state decoder; each rising edge requests one turn step.
- `reverse`  in  1  one-cycle pulse that toggles the play direction.
- `turn`  out  PW  index of the current player.
- `turn_onehot`  out  MAX_PLAYERS  one-hot copy of `turn`; all zeros when not in RUN.
- `direction`  out  1  0 = ascending, 1 = descending.
- `round_count`  out  ROUND_W  completed rounds; saturates at all-ones.
- `new_round`  out  1  one-cycle pulse on each round increment.
- `game_active`  out  1  high in RUN.
- `winner_valid`  out  1  high in HALT when exactly one player remains.
- `winner`  out  PW  index of the remaining player; valid while `winner_valid` is high.

## Operation
- Reset values: state IDLE, `turn`=0, `turn_onehot`=0, `direction`=0, `round_count`=0, `new_round`=0, `game_active`=0, `winner_valid`=0, `winner`=0, edge register `adv_q`=0.
- `adv_q` samples `advance` every cycle in every state. An edge is `advance & ~adv_q`. Holding `advance` high across `start` therefore produces no step.
- States:
  - IDLE: `start` → RUN. Latch `num_players` clamped to the range [2, MAX_PLAYERS]. Set `turn`=0, `direction`=0, `round_count`=0.
  - RUN: an edge selects the next active player. Scan from `turn`±1 modulo N in the current direction, over indices below N that are set in `active_mask`.
  - RUN → HALT, checked every cycle, whenever the masked count of active players is ≤1. If the count is 1, raise `winner_valid` and load `winner`. If the count is 0, `winner_valid`=0.
  - HALT: hold all outputs. Only `rst` leaves HALT. `start` is ignored.
- `start` is ignored in RUN and HALT. Edges and `reverse` are ignored in IDLE and HALT.
- Round rule:
  - Ascending: increment when the next index < the current index.
  - Descending: increment when the next index > the current index.
  - `new_round` pulses in the same cycle that `round_count` updates.
- Simultaneous `reverse` and edge in one cycle: the toggle applies first, so the step uses the new direction.
- If the current player is cleared in `active_mask`, `turn` holds until the next edge. The scan never returns the cleared index unless its bit is set again.
- Mask bits at indices ≥N are ignored.
- If RUN→HALT and an edge coincide, the transition to HALT wins and `turn` does not update.

## Timing
- Latency from edge to new `turn`: `advance` rises at cycle k, and `turn`, `turn_onehot`, `round_count` and `new_round` update at edge k+1.
- Latency from `start` at cycle k: RUN is entered and `game_active`=1 from k+1.
- HALT is entered one cycle after the mask condition is sampled.
- All outputs are registered. The scan is single-cycle combinational over MAX_PLAYERS bits.

## Structure
- Package `turn_pkg` holds:
  - the state enum (IDLE, RUN, HALT);
  - the direction constants `DIR_UP`=0 and `DIR_DOWN`=1;
  - the clamp function for `num_players`.
- Sub-module `ring_next_finder` is combinational. It takes the current index, direction, N and the masked vector. It returns the next index, a found flag, a wrap flag and the popcount. It is parametrised by MAX_PLAYERS.

## Test plan
- Rotation and rounds: MAX=4, N=3, mask=1111, `start`, then 4 edges → `turn` goes 1, 2, 0, 1; `round_count`=1 after the third edge with a single `new_round` pulse.
- Skip and reverse: N=4, mask=1011, `turn`=1, edge → 3. Then `reverse` and an edge in the same cycle → 1, and `direction`=1.
- Elimination: N=4, `turn`=2, mask changes 1111→0100 → next cycle HALT, `winner_valid`=1, `winner`=2, and later edges are ignored.
- Clamp and idle: `num_players`=1 → behaves as N=2. Edges sent in IDLE → `turn` stays 0, `game_active`=0.
- Level hold and reset: `advance` held high through `start` → no step; `rst` mid-RUN → all reset values on the next edge.
- Saturation: ROUND_W=2, N=2, 10 edges → `round_count` holds at 3 and `new_round` stops pulsing after the 3rd round.
